// File: rtl/cnt_ctrl_1596.sv
// rtl/cnt_ctrl_1596.sv - pushbutton front end for an up/down counter with load and auto-repeat
//
// Ports:
//   clk5m          5 MHz system clock, all logic on the rising edge
//   rst_n          synchronous active-low reset
//   btn_up_i       raw count-up pushbutton (1 = pressed)
//   btn_dn_i       raw count-down pushbutton (1 = pressed)
//   btn_ld_i       raw load pushbutton (1 = pressed)
//   sw_i           preset value from slide switches
//   en             single-cycle count enable pulse
//   updn           direction level (0 = up, 1 = down), held between pulses
//   load           single-cycle parallel-load strobe
//   data_in        load value, captured from sw_i on a load press
module cnt_ctrl_1596 #(
    parameter int WIDTH       = 10,
    parameter int DEB_CYCLES  = 50000,
    parameter int HOLD_CYCLES = 2500000,
    parameter int REP_CYCLES  = 500000
) (
    input  logic             clk5m,
    input  logic             rst_n,
    input  logic             btn_up_i,
    input  logic             btn_dn_i,
    input  logic             btn_ld_i,
    input  logic [WIDTH-1:0] sw_i,
    output logic             en,
    output logic             updn,
    output logic             load,
    output logic [WIDTH-1:0] data_in
);

    localparam int BTN_UP = 0;
    localparam int BTN_DN = 1;
    localparam int BTN_LD = 2;

    localparam int DEB_W   = (DEB_CYCLES > 1) ? $clog2(DEB_CYCLES) : 1;
    localparam int TMR_MAX = (HOLD_CYCLES > REP_CYCLES) ? HOLD_CYCLES : REP_CYCLES;
    localparam int TMR_W   = (TMR_MAX > 1) ? $clog2(TMR_MAX) : 1;

    localparam logic [DEB_W-1:0] DEB_LAST  = DEB_W'(DEB_CYCLES - 1);
    localparam logic [TMR_W-1:0] HOLD_LAST = TMR_W'(HOLD_CYCLES - 1);
    localparam logic [TMR_W-1:0] REP_LAST  = TMR_W'(REP_CYCLES - 1);

    typedef enum logic [1:0] {
        S_IDLE   = 2'd0,
        S_HOLD   = 2'd1,
        S_REPEAT = 2'd2
    } state_t;

    logic [2:0]       raw;
    logic [2:0]       sync1_q;
    logic [2:0]       sync2_q;
    logic [2:0]       deb_q;
    logic [2:0]       prev_q;
    logic [DEB_W-1:0] deb_cnt_q [3];
    logic [2:0]       press;

    state_t           state_q, state_d;
    logic             dir_q, dir_d;
    logic [TMR_W-1:0] tmr_q, tmr_d;
    logic             en_q, en_d;
    logic             load_q, load_d;
    logic             updn_q, updn_d;
    logic [WIDTH-1:0] data_q, data_d;
    logic             act_held;
    logic             other_held;

    assign raw = {btn_ld_i, btn_dn_i, btn_up_i};

    // Synchronizers and per-button debounce: the debounced level flips only
    // after DEB_CYCLES consecutive disagreeing samples; any agreement clears.
    always_ff @(posedge clk5m) begin
        if (!rst_n) begin
            sync1_q <= '0;
            sync2_q <= '0;
            deb_q   <= '0;
            prev_q  <= '0;
            for (int i = 0; i < 3; i++) begin
                deb_cnt_q[i] <= '0;
            end
        end else begin
            sync1_q <= raw;
            sync2_q <= sync1_q;
            for (int i = 0; i < 3; i++) begin
                if (sync2_q[i] != deb_q[i]) begin
                    if (deb_cnt_q[i] == DEB_LAST) begin
                        deb_q[i]     <= sync2_q[i];
                        deb_cnt_q[i] <= '0;
                    end else begin
                        deb_cnt_q[i] <= deb_cnt_q[i] + 1'b1;
                    end
                end else begin
                    deb_cnt_q[i] <= '0;
                end
            end
            // A press is only consumed in a cycle where it may pulse; while en
            // is high it stays pending so en never asserts back-to-back.
            if (!en_q) begin
                prev_q <= deb_q;
            end
        end
    end

    assign press = deb_q & ~prev_q & {3{~en_q}};

    assign act_held   = dir_q ? deb_q[BTN_DN] : deb_q[BTN_UP];
    assign other_held = dir_q ? deb_q[BTN_UP] : deb_q[BTN_DN];

    always_comb begin
        state_d = state_q;
        dir_d   = dir_q;
        tmr_d   = tmr_q;
        en_d    = 1'b0;
        load_d  = 1'b0;
        updn_d  = updn_q;
        data_d  = data_q;

        if (press[BTN_LD]) begin
            // Load wins over everything and cancels any repeat in progress.
            en_d    = 1'b1;
            load_d  = 1'b1;
            data_d  = sw_i;
            state_d = S_IDLE;
            tmr_d   = '0;
        end else begin
            case (state_q)
                S_IDLE: begin
                    if (press[BTN_UP] && !deb_q[BTN_DN]) begin
                        en_d    = 1'b1;
                        updn_d  = 1'b0;
                        dir_d   = 1'b0;
                        state_d = S_HOLD;
                        tmr_d   = '0;
                    end else if (press[BTN_DN] && !deb_q[BTN_UP]) begin
                        en_d    = 1'b1;
                        updn_d  = 1'b1;
                        dir_d   = 1'b1;
                        state_d = S_HOLD;
                        tmr_d   = '0;
                    end
                end
                S_HOLD: begin
                    if (!act_held || other_held) begin
                        state_d = S_IDLE;
                        tmr_d   = '0;
                    end else if (tmr_q == HOLD_LAST) begin
                        en_d    = 1'b1;
                        updn_d  = dir_q;
                        state_d = S_REPEAT;
                        tmr_d   = '0;
                    end else if (tmr_q != '1) begin
                        tmr_d = tmr_q + 1'b1;
                    end
                end
                S_REPEAT: begin
                    if (!act_held || other_held) begin
                        state_d = S_IDLE;
                        tmr_d   = '0;
                    end else if (tmr_q == REP_LAST) begin
                        en_d   = 1'b1;
                        updn_d = dir_q;
                        tmr_d  = '0;
                    end else if (tmr_q != '1) begin
                        tmr_d = tmr_q + 1'b1;
                    end
                end
                default: begin
                    state_d = S_IDLE;
                    tmr_d   = '0;
                end
            endcase
        end
    end

    always_ff @(posedge clk5m) begin
        if (!rst_n) begin
            state_q <= S_IDLE;
            dir_q   <= 1'b0;
            tmr_q   <= '0;
            en_q    <= 1'b0;
            load_q  <= 1'b0;
            updn_q  <= 1'b0;
            data_q  <= '0;
        end else begin
            state_q <= state_d;
            dir_q   <= dir_d;
            tmr_q   <= tmr_d;
            en_q    <= en_d;
            load_q  <= load_d;
            updn_q  <= updn_d;
            data_q  <= data_d;
        end
    end

    assign en      = en_q;
    assign load    = load_q;
    assign updn    = updn_q;
    assign data_in = data_q;

endmodule
